// File: rtl/uart_pkg.sv
// uart_pkg: shared states, register offsets and STATUS layout for the MMIO UART transmitter
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;
    localparam logic [15:0] TXDATA_OFS = 16'd0;
    localparam logic [15:0] STATUS_OFS = 16'd1;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_BUSY = 2;
    localparam int ST_OVF = 3;
    localparam int ST_CNT = 4;
    function automatic logic [3:0] sat_cnt(input int unsigned c);
        return c > 15 ? 4'd15 : c[3:0];
    endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO; a push while full is accepted only alongside a pop
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign empty = count_q == '0;
    assign full = count_q == CW'(DEPTH);
    assign count = count_q;
    assign dout = mem_q[rptr_q];
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        rptr_d = rptr_q + AW'(do_pop);
        wptr_d = wptr_q + AW'(do_push);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk)
        if (do_push) mem_q[wptr_q] <= din;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rptr_q <= '0;
            wptr_q <= '0;
            count_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            count_q <= count_d;
        end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO 8N1 transmitter (FIFO, STATUS, sticky overflow); UART_TX_PARITY_EN adds even parity
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    input  logic        dwrite_en,
    input  logic [15:0] dread_addr,
    output logic [15:0] io_rdata,
    output logic        io_hit,
    output logic        txd,
    output logic        tx_busy
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    tx_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, fifo_dout;
    logic txd_q, txd_d, ovf_q, ovf_d;
    logic push, pop, clr, empty, full, baud_end;
    logic [CW-1:0] count;
    logic [15:0] status;
    logic unused_hi;
    assign unused_hi = ^dwrite_data[15:8];
    assign push = dwrite_en && dwrite_addr == BASE_ADDR + TXDATA_OFS;
    assign clr = dwrite_en && dwrite_addr == BASE_ADDR + STATUS_OFS && dwrite_data[3];
    assign io_hit = dread_addr == BASE_ADDR + STATUS_OFS;
    assign io_rdata = io_hit ? status : 16'h0000;
    assign tx_busy = state_q != IDLE || !empty;
    assign txd = txd_q;
    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(dwrite_data[7:0]),
        .dout(fifo_dout), .empty(empty), .full(full), .count(count)
    );
    always_comb begin
        state_d = state_q;
        baud_d = baud_q;
        bit_d = bit_q;
        shift_d = shift_q;
        pop = 1'b0;
        baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
        if (state_q == IDLE) begin
            pop = !empty;
            state_d = empty ? IDLE : START;
            shift_d = empty ? shift_q : fifo_dout;
            baud_d = '0;
        end else if (!baud_end) begin
            baud_d = baud_q + 1'b1;
        end else begin
            baud_d = '0;
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d = '0;
                end
                DATA: begin
                    // rotate so the byte is intact again for the parity bit
                    shift_d = {shift_q[0], shift_q[7:1]};
                    bit_d = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
                    state_d = bit_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    state_d = STOP;
`else
                    state_d = bit_q == 3'd7 ? STOP : DATA;
`endif
                end
                default: begin
                    pop = !empty;
                    state_d = empty ? IDLE : START;
                    shift_d = empty ? shift_q : fifo_dout;
                end
            endcase
        end
`ifdef UART_TX_PARITY_EN
        txd_d = state_d == PARITY ? ^shift_d : state_d == DATA ? shift_d[0] : state_d != START;
`else
        txd_d = state_d == DATA ? shift_d[0] : state_d != START;
`endif
        ovf_d = push && full && !pop ? 1'b1 : clr ? 1'b0 : ovf_q;
        status = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL] = full;
        status[ST_BUSY] = tx_busy;
        status[ST_OVF] = ovf_q;
        status[ST_CNT +: 4] = sat_cnt(32'(count));
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            baud_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            txd_q <= 1'b1;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            txd_q <= txd_d;
            ovf_q <= ovf_d;
        end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: table vectors, corner sequences and random traffic against a frame-level model
module tb_uart_tx_mmio;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FLEN = FB * CPB;

    logic clk = 1'b0, reset = 1'b1, dwrite_en = 1'b0;
    logic [15:0] dwrite_addr = '0, dwrite_data = '0, dread_addr = '0;
    logic [15:0] io_rdata;
    logic io_hit, txd, tx_busy;
    int n_chk = 0, n_pass = 0;

    uart_tx_mmio #(.BASE_ADDR(16'hFF00), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data),
        .dwrite_en(dwrite_en), .dread_addr(dread_addr), .io_rdata(io_rdata),
        .io_hit(io_hit), .txd(txd), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // frame-level model: byte queue plus position within the current frame (-1 = line idle)
    logic [7:0] mq[$];
    int mpos = -1;
    logic [7:0] mcur = '0;
    logic movf = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == FB - 1) return 1'b1;
        return ^b;
    endfunction

    function automatic logic m_txd();
        return mpos < 0 ? 1'b1 : frame_bit(mcur, mpos / CPB);
    endfunction

    function automatic logic m_busy();
        return mpos >= 0 || mq.size() != 0;
    endfunction

    function automatic logic [15:0] m_status();
        int n = mq.size();
        return {8'h00, 4'(n > 15 ? 15 : n), movf, m_busy(), n == DEPTH, n == 0};
    endfunction

    task automatic model_edge(input logic we, input logic [15:0] wa, input logic [15:0] wd);
        bit was_full = mq.size() == DEPTH;
        bit pop = mq.size() != 0 && (mpos < 0 || mpos == FLEN - 1);
        bit psh = we && wa == 16'hFF00;
        if (pop) begin
            mcur = mq.pop_front();
            mpos = 0;
        end else if (mpos == FLEN - 1) mpos = -1;
        else if (mpos >= 0) mpos++;
        if (psh && (!was_full || pop)) mq.push_back(wd[7:0]);
        if (psh && was_full && !pop) movf = 1'b1;
        else if (we && wa == 16'hFF01 && wd[3]) movf = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic do_reset();
        dwrite_en = 1'b0;
        reset = 1'b1;
        mq.delete();
        mpos = -1;
        movf = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step(input logic we, input logic [15:0] wa, input logic [15:0] wd, input logic [15:0] ra);
        dwrite_en = we;
        dwrite_addr = wa;
        dwrite_data = wd;
        dread_addr = ra;
        @(posedge clk);
        model_edge(we, wa, wd);
        #1;
    endtask

    task automatic cyc(input logic we, input logic [15:0] wa, input logic [15:0] wd, input logic [15:0] ra);
        step(we, wa, wd, ra);
        chk("txd", txd, m_txd());
        chk("tx_busy", tx_busy, m_busy());
        chk("io_hit", io_hit, ra == 16'hFF01);
        chk("io_rdata", io_rdata, ra == 16'hFF01 ? m_status() : 16'h0000);
    endtask

    task automatic wait_idle(input string nm, input int exp_n);
        int n = 0;
        do begin
            cyc(1'b0, 16'h0000, 16'h0000, 16'hFF01);
            n++;
        end while (tx_busy && n < 2000);
        chk(nm, n, exp_n);
    endtask

    typedef struct {
        logic we;
        logic [15:0] wa, wd, ra;
        logic hit;
        logic [15:0] rdata;
        logic txd, busy;
    } vec_t;
    vec_t vt[8];

    initial begin
        logic [FB-1:0] frame55;
`ifdef UART_TX_PARITY_EN
        frame55 = {1'b1, 1'b0, 8'h55, 1'b0};
`else
        frame55 = {1'b1, 8'h55, 1'b0};
`endif
        vt[0] = '{1'b0, 16'h0000, 16'h0000, 16'hFF01, 1'b1, 16'h0001, 1'b1, 1'b0};
        vt[1] = '{1'b0, 16'h0000, 16'h0000, 16'hFF00, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{1'b1, 16'hFF00, 16'h1255, 16'hFF01, 1'b1, 16'h0014, 1'b1, 1'b1};
        vt[3] = '{1'b0, 16'h0000, 16'h0000, 16'hFF01, 1'b1, 16'h0005, 1'b0, 1'b1};
        vt[4] = '{1'b1, 16'hFF01, 16'h0008, 16'hFF01, 1'b1, 16'h0005, 1'b0, 1'b1};
        vt[5] = '{1'b1, 16'h1234, 16'hFFFF, 16'hFF01, 1'b1, 16'h0005, 1'b0, 1'b1};
        vt[6] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
        vt[7] = '{1'b0, 16'h0000, 16'h0000, 16'hFF01, 1'b1, 16'h0005, 1'b1, 1'b1};

        do_reset();
        chk("reset_txd", txd, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].ra);
            chk($sformatf("vec%0d_hit", i), io_hit, vt[i].hit);
            chk($sformatf("vec%0d_rdata", i), io_rdata, vt[i].rdata);
            chk($sformatf("vec%0d_txd", i), txd, vt[i].txd);
            chk($sformatf("vec%0d_busy", i), tx_busy, vt[i].busy);
        end

        do_reset();
        cyc(1'b1, 16'hFF00, 16'h1255, 16'hFF01);
        for (int k = 0; k < FLEN; k++) begin
            cyc(1'b0, 16'h0000, 16'h0000, 16'hFF00);
            if (k % CPB == CPB / 2) chk($sformatf("single_bit%0d", k / CPB), txd, frame55[k / CPB]);
        end
        chk("single_busy_last", tx_busy, 1'b1);
        cyc(1'b0, 16'h0000, 16'h0000, 16'hFF01);
        chk("single_busy_drop", tx_busy, 1'b0);

        do_reset();
        cyc(1'b1, 16'hFF00, 16'h0041, 16'h0000);
        cyc(1'b1, 16'hFF00, 16'h0042, 16'h0000);
        cyc(1'b1, 16'hFF00, 16'h0043, 16'hFF01);
        chk("burst_count", io_rdata[7:4], 4'd2);
        wait_idle("burst_cycles", 3 * FLEN - 1);

        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'hFF00, 16'(16'h10 + i), 16'hFF01);
        chk("ovf_status", io_rdata, 16'h004E);
        cyc(1'b1, 16'hFF01, 16'h0008, 16'hFF01);
        chk("ovf_clear", io_rdata, 16'h0046);
        wait_idle("ovf_cycles", 5 * FLEN - 5);

        do_reset();
        cyc(1'b1, 16'hFF00, 16'h00A5, 16'h0000);
        repeat (17) cyc(1'b0, 16'h0000, 16'h0000, 16'h0000);
        chk("mid_txd_before", txd, 1'b0);
        chk("mid_busy_before", tx_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_txd", txd, 1'b1);
        chk("mid_reset_busy", tx_busy, 1'b0);
        mq.delete();
        mpos = -1;
        movf = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 16'h0000, 16'h0000, 16'hFF01);
        chk("mid_reset_status", io_rdata, 16'h0001);

        for (int i = 0; i < 3000; i++) begin
            int rate = (i / 500) % 2 == 1 ? 2 : 35;
            logic we = $urandom_range(99) < rate;
            int sel = $urandom_range(9);
            int rs = $urandom_range(3);
            logic [15:0] wa = sel < 6 ? 16'hFF00 : sel < 8 ? 16'hFF01 : 16'($urandom);
            logic [15:0] ra = rs < 2 ? 16'hFF01 : rs == 2 ? 16'hFF00 : 16'($urandom);
            cyc(we, wa, 16'($urandom), ra);
        end
        for (int i = 0; i < 400 && tx_busy; i++) cyc(1'b0, 16'h0000, 16'h0000, 16'hFF01);
        chk("drain_busy", tx_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped serial transmitter that sits downstream of the CPU data-write port, alongside the data memory. CPU stores to a fixed address push bytes into a small FIFO, and a bit-serial engine shifts them out as 8N1 frames on `txd`. A status register is readable through the CPU data-read port, so test programs can poll for space and completion and benches can observe program output.

## Interface
- `BASE_ADDR`, 16'hFF00: TXDATA register address; STATUS is at `BASE_ADDR+1`.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; minimum 1.
- `FIFO_DEPTH`, 4: byte entries; must be a power of two, at least 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `dwrite_addr` in 16: CPU data-write address.
- `dwrite_data` in 16: CPU data-write data; only bits [7:0] are used for TXDATA.
- `dwrite_en` in 1: CPU data-write strobe, one cycle per store.
- `dread_addr` in 16: CPU data-read address.
- `io_rdata` out 16: STATUS value when `io_hit` is 1, else 0.
- `io_hit` out 1: `dread_addr == BASE_ADDR+1`; the system mux selects `io_rdata` over memory.
- `txd` out 1: serial line, idle high.
- `tx_busy` out 1: engine is not IDLE or the FIFO is non-empty.

## Operation
- **Push:** `dwrite_en && dwrite_addr==BASE_ADDR` writes `dwrite_data[7:0]` to the FIFO tail.
  - If the FIFO is full and no pop happens in the same cycle, the byte is dropped and sticky `ovf` is set.
  - A push while full with a simultaneous pop is accepted; the count is unchanged.
- **Overflow clear:** `dwrite_en && dwrite_addr==BASE_ADDR+1 && dwrite_data[3]` clears `ovf`. Setting `ovf` in the same cycle takes priority.
- **STATUS bits:**
  - [0] empty
  - [1] full
  - [2] `tx_busy`
  - [3] `ovf`
  - [7:4] FIFO count, saturating at 15
  - [15:8] zero
- **Engine states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The head byte is popped into an 8-bit shift register in that cycle.
  - START drives `txd`=0.
  - DATA drives `shift[0]` for 8 bits, LSB first, with a bit index of 0..7.
  - STOP drives `txd`=1.
  - STOP → START directly if the FIFO is non-empty at the end of STOP (pop in that cycle). Otherwise STOP → IDLE.
- **Bit timing:** a baud counter counts 0..`CLKS_PER_BIT`-1; each state/bit lasts exactly `CLKS_PER_BIT` cycles.
- **Writes elsewhere:** writes to any other address are ignored. Reads have no side effects.
- **Reset:**
  - State: FIFO empty, `ovf`=0, state IDLE, counters 0.
  - Outputs: `txd`=1, `tx_busy`=0, `io_rdata`=0 (while `io_hit`=0).
  - Mid-frame reset aborts the frame; `txd` returns high immediately (asynchronously).

## Timing
- `io_hit` and `io_rdata` are combinational from `dread_addr` and the current registers; there is no read latency.
- **Push-to-line latency:** a store at edge N into an empty FIFO with the engine IDLE makes the FIFO non-empty after N. The pop/START transition happens at N+1, and `txd` falls after edge N+1.
- **Frame length:** 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- **Back-to-back frames:** no idle gap between STOP and the next START.
- STATUS reflects a push on the cycle after the write edge.
- `txd` is registered and glitch-free.

## Configuration
- **`UART_TX_PARITY_EN`**
  - Defined: a PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits).
  - Undefined: no PARITY state; frames are 8N1.

## Structure
- **Package `uart_pkg`:**
  - state enum `tx_state_t` (IDLE, START, DATA, [PARITY], STOP)
  - register offsets `TXDATA_OFS`=0, `STATUS_OFS`=1
  - STATUS bit-position constants
- **Sub-module `uart_fifo`:** synchronous FIFO with parameters width and depth.
  - ports: `clk`, `reset`, `push`, `pop`, `din`, `dout`, `empty`, `full`, `count`
  - pop and push in the same cycle are allowed when full or empty as defined above.
- **Top:** address decode, `ovf`, baud/bit counters and the shift FSM live in `uart_tx_mmio`.

## Test plan
All scenarios use the default parameters unless stated.
- **Reset:** assert `reset` mid-frame (during DATA bit 3) → `txd`=1 and `tx_busy`=0 immediately; STATUS reads 16'h0001 after release.
- **Single byte:** store 16'h1255 to 16'hFF00 → starting 1 cycle later, `txd` holds each bit for 4 cycles: 0,1,0,1,0,1,0,1,0,1. `tx_busy` drops after 40 cycles.
- **Burst:** 3 consecutive stores 8'h41, 8'h42, 8'h43 → 3 frames back-to-back, 120 cycles total with no idle gap. STATUS read after the 3rd store shows count 2 (one already popped).
- **Overflow:** 6 stores in 6 consecutive cycles → 5 bytes transmitted (1 popped + 4 queued), STATUS[3]=1. A store of 16'h0008 to 16'hFF01 clears it.
- **Read mux:** `dread_addr`=16'hFF01 → `io_hit`=1 and `io_rdata`=STATUS. `dread_addr`=16'hFF00 → `io_hit`=0 and `io_rdata`=0.
- **Parity (`UART_TX_PARITY_EN` defined):** send 8'h07 → parity bit 1, frame of 44 cycles.
